// File: rtl/line_sequencer.sv
// Line sequencer: walks a line-pointer table in shared memory and streams each
// line's character pairs through a valid/ready port, one memory request per state.
module line_sequencer #(
  parameter logic [7:0] PTR_BASE = 8'hE0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  first_line,
  input  logic [7:0]  num_lines,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_lhs,
  output logic [7:0]  out_rhs,
  output logic        out_last,
  output logic        line_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PTR       = 3'd1;
  localparam logic [2:0] S_PTR_WAIT  = 3'd2;
  localparam logic [2:0] S_CHAR      = 3'd3;
  localparam logic [2:0] S_CHAR_WAIT = 3'd4;
  localparam logic [2:0] S_EMIT      = 3'd5;
  localparam logic [2:0] S_LINE_END  = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0] state_q,      state_d;
  logic [7:0] cur_line_q,   cur_line_d;
  logic [7:0] lines_left_q, lines_left_d;
  logic [7:0] char_addr_q,  char_addr_d;
  logic [7:0] chars_left_q, chars_left_d;
  logic       out_valid_q,  out_valid_d;
  logic [7:0] out_lhs_q,    out_lhs_d;
  logic [7:0] out_rhs_q,    out_rhs_d;
  logic       out_last_q,   out_last_d;

  logic start_accept;
  assign start_accept = (state_q == S_IDLE) && start && !abort && !rst;

  // busy also covers the cycle in which start is accepted.
  assign busy      = (state_q != S_IDLE) || start_accept;
  assign done      = (state_q == S_DONE)     && !abort && !rst;
  assign line_done = (state_q == S_LINE_END) && !abort && !rst;

  always_comb begin
    unique case (state_q)
      S_PTR:   mem_addr = PTR_BASE + cur_line_q;
      S_CHAR:  mem_addr = char_addr_q;
      default: mem_addr = 8'hFF;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_lhs   = out_lhs_q;
  assign out_rhs   = out_rhs_q;
  assign out_last  = out_last_q;

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    cur_line_d   = cur_line_q;
    lines_left_d = lines_left_q;
    char_addr_d  = char_addr_q;
    chars_left_d = chars_left_q;
    out_valid_d  = out_valid_q;
    out_lhs_d    = out_lhs_q;
    out_rhs_d    = out_rhs_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          cur_line_d   = first_line;
          lines_left_d = num_lines;
          state_d      = (num_lines == 8'd0) ? S_DONE : S_PTR;
        end
      end
      S_PTR: state_d = S_PTR_WAIT;
      S_PTR_WAIT: begin
        char_addr_d  = mem_dout[7:0];
        chars_left_d = mem_dout[15:8];
        state_d      = (mem_dout[15:8] == 8'd0) ? S_LINE_END : S_CHAR;
      end
      S_CHAR: state_d = S_CHAR_WAIT;
      S_CHAR_WAIT: begin
        out_lhs_d   = mem_dout[15:8];
        out_rhs_d   = mem_dout[7:0];
        out_valid_d = 1'b1;
        out_last_d  = (chars_left_q == 8'd1);
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          char_addr_d  = char_addr_q + 8'd1;
          chars_left_d = chars_left_q - 8'd1;
          state_d      = (chars_left_q == 8'd1) ? S_LINE_END : S_CHAR;
        end
      end
      S_LINE_END: begin
        cur_line_d   = cur_line_q + 8'd1;
        lines_left_d = lines_left_q - 8'd1;
        state_d      = (lines_left_q == 8'd1) ? S_DONE : S_PTR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops any unaccepted pair; the data registers keep their last values.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_line_q   <= 8'd0;
      lines_left_q <= 8'd0;
      char_addr_q  <= 8'd0;
      chars_left_q <= 8'd0;
      out_valid_q  <= 1'b0;
      out_lhs_q    <= 8'd0;
      out_rhs_q    <= 8'd0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_line_q   <= cur_line_d;
      lines_left_q <= lines_left_d;
      char_addr_q  <= char_addr_d;
      chars_left_q <= chars_left_d;
      out_valid_q  <= out_valid_d;
      out_lhs_q    <= out_lhs_d;
      out_rhs_q    <= out_rhs_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule

// File: doc/line_sequencer.md
LINE_SEQUENCER -- requirements
Module: line_sequencer

Interface
REQ-001 SHALL have parameter PTR_BASE, default 8'hE0, base word address of the line pointer table in the shared memory.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock; all state updates on rising edge
 rst  in  1  synchronous, active-high reset
 start  in  1  one-cycle request to print a run of lines
 abort  in  1  synchronous cancel of the current run
 first_line  in  8  index of first line, sampled on accepted start
 num_lines  in  8  number of lines to print, sampled on accepted start
 busy  out  1  high from accepted start until return to IDLE
 done  out  1  one-cycle pulse when a run completes normally
 mem_addr  out  8  word address to shared memory, the only memory port
 mem_dout  in  16  memory read data, valid one cycle after mem_addr
 out_valid  out  1  character pair available
 out_ready  in  1  downstream accepts pair when high with out_valid
 out_lhs  out  8  input character, mem_dout[15:8] of char word
 out_rhs  out  8  transformed character, mem_dout[7:0] of char word
 out_last  out  1  qualifies out_valid: final pair of current line
 line_done  out  1  one-cycle pulse after a line's last pair (or empty line)

Function
REQ-003 SHALL share mem_addr between pointer-table reads and character reads; exactly one request per state, no overlap.
REQ-004 Pointer word format SHALL be: [7:0] line start address, [15:8] line length in pairs.
REQ-005 States SHALL be IDLE, PTR, PTR_WAIT, CHAR, CHAR_WAIT, EMIT, LINE_END, DONE.
REQ-006 IDLE: busy=0, mem_addr=8'hFF; start=1 latches first_line into cur_line and num_lines into lines_left; -> DONE if num_lines==0, else -> PTR.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 PTR: mem_addr = PTR_BASE + cur_line, 8-bit wrap; -> PTR_WAIT.
REQ-009 PTR_WAIT: latch char_addr=mem_dout[7:0], chars_left=mem_dout[15:8]; -> LINE_END if length 0, else -> CHAR.
REQ-010 CHAR: mem_addr=char_addr; -> CHAR_WAIT.
REQ-011 CHAR_WAIT: register mem_dout into out_lhs/out_rhs, set out_valid=1, out_last=(chars_left==1); -> EMIT.
REQ-012 EMIT: hold out_valid, out_lhs, out_rhs, out_last stable until out_ready=1; on handshake, out_valid=0 next cycle, char_addr+1 (8-bit wrap 8'hFF->8'h00), chars_left-1; -> LINE_END if chars_left was 1, else -> CHAR.
REQ-013 Minimum cost SHALL be 3 cycles per pair with out_ready held high; no pair is ever dropped or duplicated.
REQ-014 LINE_END: line_done=1 for that cycle; cur_line+1 (8-bit wrap); lines_left-1; -> DONE if lines_left was 1, else -> PTR.
REQ-015 DONE: done=1 for that cycle; -> IDLE; busy=0 from the IDLE cycle.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE next cycle: out_valid=0, no line_done, no done pulse; an in-flight unaccepted pair is discarded.
REQ-017 abort and start together in IDLE: abort SHALL win; no run starts.
REQ-018 out_lhs/out_rhs SHALL retain last emitted values when out_valid=0.
REQ-019 mem_addr SHALL be 8'hFF in every state not issuing a read (IDLE, PTR_WAIT, CHAR_WAIT, EMIT, LINE_END, DONE).

Reset
REQ-020 rst SHALL be synchronous, active-high, and override start/abort; reset-mid-run returns to IDLE next cycle.
REQ-021 Reset values: state IDLE, mem_addr 8'hFF, busy 0, done 0, out_valid 0, out_lhs 8'h00, out_rhs 8'h00, out_last 0, line_done 0, internal counters 0.

Verification
REQ-022 Table[PTR_BASE+2]=16'h0310, mem[10..12]=16'h4142,16'h4344,16'h4546; start first_line=2 num_lines=1, out_ready=1 -> pairs (41,42),(43,44),(45,46), out_last on third only, one line_done, then done, 3 cycles per pair.
REQ-023 Same run with out_ready low 5 cycles on second pair -> out_valid and (43,44) held stable 5 cycles, no duplicate pair after release.
REQ-024 Line with length 0 followed by line length 1, num_lines=2 -> no out_valid for first line, two line_done pulses, one pair emitted, one done.
REQ-025 num_lines=0 -> busy 2 cycles, done pulse, no memory read (mem_addr stays 8'hFF), no line_done.
REQ-026 Wrap: first_line=8'h1F with PTR_BASE 8'hE0 reads pointer at 8'hFF then 8'h00; line start 8'hFF length 2 reads chars at 8'hFF then 8'h00.
REQ-027 abort asserted during EMIT with out_ready low, and separately rst during CHAR -> next cycle IDLE, out_valid 0, mem_addr 8'hFF, no done; subsequent start runs normally.
